// File: rtl/tetris_pkg.sv
// Shared definitions for the Tetris game core: gravity FSM states and the
// default gravity period constants.
package tetris_pkg;

   typedef enum logic [1:0] {
      STOP = 2'd0,
      RUN  = 2'd1,
      HOLD = 2'd2
   } gs_state_t;

   // Carry pulses per gravity tick at level 0.
   localparam int BASE_PERIOD = 48;
   // Period reduction per level.
   localparam int STEP        = 3;
   // Fastest period reachable through level alone.
   localparam int MIN_PERIOD  = 2;
   // Period while the player holds soft drop.
   localparam int SOFT_PERIOD = 2;

endpackage

// File: rtl/gravity_tick_gen_if.sv
// Control/status bundle between the game FSM side and the gravity tick
// generator. The master drives the control inputs and the ack; the slave
// (the generator) returns the tick request and status.
interface gravity_tick_gen_if #(
   parameter int W = 8
);
   logic         en_pulse;
   logic [3:0]   level;
   logic         start;
   logic         restart;
   logic         pause;
   logic         soft_drop;
   logic         tick_ack;
   logic         tick;
   logic         missed;
   logic         running;
   logic [W-1:0] cnt;

   modport master (
      output en_pulse, level, start, restart, pause, soft_drop, tick_ack,
      input  tick, missed, running, cnt
   );

   modport slave (
      input  en_pulse, level, start, restart, pause, soft_drop, tick_ack,
      output tick, missed, running, cnt
   );
endinterface

// File: rtl/gravity_period_lut.sv
// Maps game level and soft-drop state to the gravity period in carry pulses.
// Purely combinational; the level term is computed in a widened domain so a
// large level never wraps below zero, it simply clamps to the minimum.
module gravity_period_lut #(
   parameter int W           = 8,
   parameter int BASE_PERIOD = tetris_pkg::BASE_PERIOD,
   parameter int STEP        = tetris_pkg::STEP,
   parameter int MIN_PERIOD  = tetris_pkg::MIN_PERIOD,
   parameter int SOFT_PERIOD = tetris_pkg::SOFT_PERIOD
) (
   input  logic [3:0]   level,
   input  logic         soft_drop,
   output logic [W-1:0] period
);
   localparam int XW = W + 4;
   localparam logic [XW-1:0] BASE_X = XW'(BASE_PERIOD);
   localparam logic [XW-1:0] STEP_X = XW'(STEP);
   localparam logic [XW-1:0] MIN_X  = XW'(MIN_PERIOD);
   localparam logic [W-1:0]  MIN_W  = W'(MIN_PERIOD);
   localparam logic [W-1:0]  SOFT_W = W'(SOFT_PERIOD);

   logic [XW-1:0] step_x;
   logic [XW-1:0] diff_x;
   logic [W-1:0]  lvl_period;

   // Level period with floor clamp, then soft-drop ceiling.
   always_comb begin
      step_x     = STEP_X * {{W{1'b0}}, level};
      diff_x     = '0;
      lvl_period = MIN_W;
      if (step_x < BASE_X) begin
         diff_x = BASE_X - step_x;
         if (diff_x > MIN_X) begin
            lvl_period = diff_x[W-1:0];
         end
      end
      period = lvl_period;
      if (soft_drop && (lvl_period > SOFT_W)) begin
         period = SOFT_W;
      end
   end

endmodule

// File: rtl/gravity_tick_gen.sv
// Gravity tick generator: divides the prescaler carry by a level-dependent
// period and raises a held drop request with ack handshake, soft-drop
// acceleration, pause and per-piece restart.
module gravity_tick_gen #(
   parameter int W           = 8,
   parameter int BASE_PERIOD = tetris_pkg::BASE_PERIOD,
   parameter int STEP        = tetris_pkg::STEP,
   parameter int MIN_PERIOD  = tetris_pkg::MIN_PERIOD,
   parameter int SOFT_PERIOD = tetris_pkg::SOFT_PERIOD
) (
   input  logic              CP,
   input  logic              CR,
   gravity_tick_gen_if.slave bus
);
   import tetris_pkg::*;

   localparam logic [W-1:0] SOFT_M1 = W'(SOFT_PERIOD - 1);

   gs_state_t    state_reg, state_next;
   logic [W-1:0] cnt_reg, cnt_next;
   logic         tick_reg, tick_next;
   logic         missed_reg, missed_next;
   logic         sd_prev_reg;
   logic [W-1:0] period;
   logic [W-1:0] reload;
   logic         sd_edge;
   logic         due;

   gravity_period_lut #(
      .W           (W),
      .BASE_PERIOD (BASE_PERIOD),
      .STEP        (STEP),
      .MIN_PERIOD  (MIN_PERIOD),
      .SOFT_PERIOD (SOFT_PERIOD)
   ) u_period_lut (
      .level     (bus.level),
      .soft_drop (bus.soft_drop),
      .period    (period)
   );

   assign reload  = period - W'(1);
   assign sd_edge = bus.soft_drop & ~sd_prev_reg;

   // State, counter, handshake and soft-drop history registers.
   always_ff @(posedge CP or posedge CR) begin
      if (CR) begin
         state_reg   <= STOP;
         cnt_reg     <= '0;
         tick_reg    <= 1'b0;
         missed_reg  <= 1'b0;
         sd_prev_reg <= 1'b0;
      end else begin
         state_reg   <= state_next;
         cnt_reg     <= cnt_next;
         tick_reg    <= tick_next;
         missed_reg  <= missed_next;
         sd_prev_reg <= bus.soft_drop;
      end
   end

   // Next state, counter and handshake; restart overrides everything,
   // then start/pause, then the soft-drop clamp, then the carry pulse.
   always_comb begin
      state_next  = state_reg;
      cnt_next    = cnt_reg;
      tick_next   = tick_reg;
      missed_next = missed_reg;
      due         = 1'b0;
      if (bus.restart) begin
         state_next  = RUN;
         cnt_next    = reload;
         tick_next   = 1'b0;
         missed_next = 1'b0;
      end else begin
         unique case (state_reg)
            STOP: begin
               if (bus.start) begin
                  state_next = RUN;
                  cnt_next   = reload;
               end
            end
            RUN: begin
               if (bus.pause) begin
                  state_next = HOLD;
               end else if (sd_edge) begin
                  if (cnt_reg > SOFT_M1) begin
                     cnt_next = SOFT_M1;
                  end
               end else if (bus.en_pulse) begin
                  if (cnt_reg == '0) begin
                     due      = 1'b1;
                     cnt_next = reload;
                  end else begin
                     cnt_next = cnt_reg - W'(1);
                  end
               end
            end
            HOLD: begin
               if (!bus.pause) begin
                  state_next = RUN;
               end
            end
            default: state_next = STOP;
         endcase
         // A new due event wins over a same-cycle ack and is not a miss.
         if (due) begin
            if (tick_reg && !bus.tick_ack) begin
               missed_next = 1'b1;
            end
            tick_next = 1'b1;
         end else if (bus.tick_ack) begin
            tick_next = 1'b0;
         end
      end
   end

   assign bus.tick    = tick_reg;
   assign bus.missed  = missed_reg;
   assign bus.cnt     = cnt_reg;
   assign bus.running = (state_reg == RUN);

endmodule

// File: doc/gravity_tick_gen.md
# gravity_tick_gen

Programmable gravity-tick generator for the Tetris game core. It sits directly downstream of the cascaded 4-bit prescaler counters. It consumes their terminal-count carry as a one-cycle enable and divides it by a level-dependent period. It raises a held "drop one row" request to the game FSM, with an acknowledge handshake, soft-drop acceleration, pause and per-piece restart.

## Interface
- W, 8, width of the period down-counter
- BASE_PERIOD, 48, carry pulses per tick at level 0
- STEP, 3, period decrement per level
- MIN_PERIOD, 2, lower clamp on level period
- SOFT_PERIOD, 2, period while soft drop held
- CP  in  1  clock, rising edge
- CR  in  1  reset, asynchronous, active-high
- en_pulse  in  1  prescaler carry, one CP cycle wide
- level  in  4  current game level 0..15
- start  in  1  leave STOP, begin counting
- restart  in  1  sync reload on new piece spawn
- pause  in  1  level-sensitive freeze
- soft_drop  in  1  level-sensitive fast fall
- tick_ack  in  1  game FSM consumed tick
- tick  out  1  drop request, held until acked
- missed  out  1  sticky: tick due while previous unacked
- running  out  1  high in RUN state
- cnt  out  W  current down-counter value

## Operation
- Level period: P_lvl = max(BASE_PERIOD − STEP·level, MIN_PERIOD). Compute at W bits, with no underflow wrap; negative intermediate results clamp to MIN_PERIOD.
- Effective period: P = min(P_lvl, SOFT_PERIOD) while soft_drop=1, else P_lvl.
- FSM states: STOP (reset state), RUN, HOLD.
  - STOP→RUN on start, loading cnt=P−1.
  - RUN→HOLD on pause=1.
  - HOLD→RUN on pause=0.
  - Any state→RUN on restart.
- Counting happens in RUN only, on cycles with en_pulse=1:
  - If cnt==0, set tick and reload cnt=P−1.
  - Otherwise cnt−1.
- One tick every P carry pulses.
- level change mid-count: does not disturb cnt; the new P applies at the next reload.
- soft_drop rising edge in RUN: cnt ← min(cnt, SOFT_PERIOD−1), evaluated the same cycle. It takes priority over that cycle's decrement.
- Handshake:
  - tick stays high until a cycle with tick_ack=1, then clears.
  - If ack and a new tick-due event occur in the same cycle, tick stays 1 and missed is not set.
  - tick_ack while tick=0 is ignored.
- missed: set when a tick-due event occurs while tick=1 and tick_ack=0. Cleared only by restart or CR.
- HOLD: cnt, tick and missed are frozen. en_pulse is ignored. tick_ack is still honoured (clears tick).
- Priority, highest first: CR > restart > start > pause > soft_drop edge > en_pulse.
- restart: cnt=P−1, tick=0, missed=0, state RUN, regardless of the current state.

## Timing
- Reset values: state STOP, cnt=0, tick=0, missed=0, running=0. Soft-drop edge detector register=0.
- All outputs are registered. tick rises on the CP edge that samples en_pulse=1 with cnt==0, so it is visible in the next cycle.
- tick clears on the edge that samples tick_ack=1.
- running follows the state register, with no combinational path from inputs.
- CR asserted mid-count or mid-handshake clears everything immediately, without waiting for a clock edge. Counting resumes only after a new start.
- en_pulse longer than one cycle counts once per cycle it is high. The upstream block guarantees single-cycle pulses.

## Structure
- Shared package tetris_pkg:
  - state enum typedef gs_state_t {STOP, RUN, HOLD}.
  - default period constants (BASE_PERIOD, STEP, MIN_PERIOD, SOFT_PERIOD).
- One sub-module: gravity_period_lut. It is purely combinational, mapping level and soft_drop to P with clamping, so it can be tested exhaustively on its own.
- Top module holds:
  - the FSM
  - the down-counter
  - the soft-drop edge register
  - the tick/missed handshake logic

## Test plan
- Reset, start at level 0, constant ack → first tick after exactly 48 en_pulses, then every 48. cnt reads 47 right after start.
- level=15 → period clamps to 3; level=5 set mid-count → current interval unchanged, next interval 33.
- No ack, two periods at level 15 → tick held high, missed=1 after the second due event. restart → tick=0, missed=0, cnt=2.
- soft_drop rises with cnt=30 → cnt=1 next cycle, tick after 2 more en_pulses, then every 2. Release → next reload uses P_lvl.
- pause during count with en_pulses arriving → cnt frozen, running=0. tick_ack in HOLD clears tick. Unpause → counting resumes from the frozen cnt.
- CR pulsed asynchronously between clock edges while tick=1 → tick, missed, cnt all 0 immediately, state STOP; en_pulses ignored until start.
